rf_write_ctrl: RTL and testbench
================================

RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-write queue entries (power of 2, >=2).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 a_valid  in  1  port A (pipeline writeback) write request.
REQ-006 a_addr  in  5  port A destination register.
REQ-007 a_data  in  32  port A write data.
REQ-008 a_ready  out  1  port A request accepted this cycle when high with a_valid.
REQ-009 b_valid, b_addr[4:0], b_data[31:0] in; b_ready out: port B (multi-cycle/load unit), same meaning as port A.
REQ-010 wb_hold  in  1  blocks draining to register file while high.
REQ-011 rf_wen  out  1  write enable to register-file write port.
REQ-012 rf_addr_w  out  5  register-file write address.
REQ-013 rf_data_w  out  32  register-file write data.
REQ-014 q_addr1, q_addr2  in  5  forwarding lookup addresses.
REQ-015 q_hit1, q_hit2  out  1  lookup address matches a pending queue entry.
REQ-016 q_data1, q_data2  out  32  data of youngest matching pending entry, else 0.

Function
REQ-017 SHALL hold pending writes in a DEPTH-entry FIFO (addr+data), count 0..DEPTH.
REQ-018 SHALL accept at most one request per cycle; handshake = valid & ready at posedge.
REQ-019 a_ready SHALL be (count < DEPTH) & !(b_valid & starve); b_ready SHALL be (count < DEPTH) & (!a_valid | starve).
REQ-020 Ready SHALL NOT account for a same-cycle pop (no pass-through when full).
REQ-021 starve SHALL be (b_wait == 3); b_wait 2-bit counter: +1 (saturating) each cycle b_valid & !b accept, cleared on B accept or !b_valid.
REQ-022 Accepted request with addr 0 SHALL be acknowledged but not enqueued.
REQ-023 rf_wen SHALL equal (count != 0) & !wb_hold; rf_addr_w/rf_data_w SHALL equal FIFO head when count != 0, else 0.
REQ-024 Head SHALL be popped at every posedge where rf_wen is high.
REQ-025 Latency: request accepted at posedge N into an empty FIFO SHALL appear on rf_wen/rf_addr_w/rf_data_w during cycle N+1 (wb_hold low).
REQ-026 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 Writes SHALL drain in acceptance order; data of the register file is updated strictly in that order.
REQ-028 Lookup SHALL be combinational over valid entries; multiple matches return youngest; q_addr 0 never hits; entry being popped this cycle still counts as pending.
REQ-029 Inputs while valid low SHALL be ignored; requesters must hold addr/data stable until accepted.

Reset
REQ-030 On rst: count=0, pointers=0, b_wait=0; rf_wen=0, rf_addr_w=0, rf_data_w=0, q_hit*=0, q_data*=0, a_ready=b_ready=1 (if not starving) next cycle.
REQ-031 Reset mid-operation SHALL discard all pending entries without issuing writes; rf_wen low in the cycle after rst sampled high.
REQ-032 Requests presented while rst high SHALL NOT be accepted.

Verification
REQ-033 A writes (r5,0x11) at cycle 1, hold low -> cycle 2 rf_wen=1, rf_addr_w=5, rf_data_w=0x11; cycle 3 rf_wen=0.
REQ-034 wb_hold=1, A pushes r1..r4 (data 1..4) -> count 4, a_ready=0; q_addr1=3 -> q_hit1=1, q_data1=3; release hold -> writes r1,r2,r3,r4 on four consecutive cycles.
REQ-035 A and B valid continuously with hold high and queue draining disabled-then-enabled -> B accepted on 4th cycle of waiting (starve), A accepted otherwise.
REQ-036 Hold high, A pushes (r7,0xA) then (r7,0xB) -> q_addr2=7 gives q_data2=0xB; drain writes 0xA then 0xB.
REQ-037 A pushes (r0,0xFF) -> a_ready=1, count stays 0, rf_wen never asserts.
REQ-038 Queue holding 3 entries, rst pulsed one cycle -> rf_wen=0 thereafter, q_hit*=0, no pending writes issued.

Source files
------------

// File: rtl/rf_write_ctrl.sv
// Register-file write controller: arbitrates two writeback ports into a pending-write
// FIFO, drains it in acceptance order and forwards the youngest pending data to lookups.
module rf_write_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        wb_hold,
    output logic        rf_wen,
    output logic [4:0]  rf_addr_w,
    output logic [31:0] rf_data_w,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic [31:0] q_data1,
    output logic [31:0] q_data2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_b_wait;

    logic          w_starve;
    logic          w_not_full;
    logic          w_a_acc;
    logic          w_b_acc;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_push_addr;
    logic [31:0]   w_push_data;
    logic [4:0]    w_q_addr [2];
    logic          w_q_hit  [2];
    logic [31:0]   w_q_data [2];

    assign w_starve   = (r_b_wait == 2'd3);
    assign w_not_full = (r_count < FULL_CNT);

    // Port readiness; nothing is accepted while reset is asserted.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end else begin
            a_ready = w_not_full & ~(b_valid & w_starve);
            b_ready = w_not_full & (~a_valid | w_starve);
        end
    end

    assign w_a_acc = a_valid & a_ready;
    assign w_b_acc = b_valid & b_ready;

    // Select the accepted request; the two readies are mutually exclusive when both are valid.
    always_comb begin
        w_push_addr = 5'd0;
        w_push_data = 32'd0;
        if (w_b_acc) begin
            w_push_addr = b_addr;
            w_push_data = b_data;
        end else begin
            w_push_addr = a_addr;
            w_push_data = a_data;
        end
    end

    // Writes to r0 are acknowledged but never queued.
    assign w_push = (w_a_acc | w_b_acc) & (w_push_addr != 5'd0);
    assign w_pop  = rf_wen;

    // Register-file write port driven from the FIFO head.
    always_comb begin
        rf_wen    = 1'b0;
        rf_addr_w = 5'd0;
        rf_data_w = 32'd0;
        if (rst) begin
            rf_wen = 1'b0;
        end else begin
            rf_wen = (r_count != {CW{1'b0}}) & ~wb_hold;
        end
        if (r_count != {CW{1'b0}}) begin
            rf_addr_w = r_addr[r_rd_ptr];
            rf_data_w = r_data[r_rd_ptr];
        end else begin
            rf_addr_w = 5'd0;
            rf_data_w = 32'd0;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= w_push_addr;
            r_data[r_wr_ptr] <= w_push_data;
        end
    end

    // Port B starvation counter: saturates while B waits, clears on accept or withdrawal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_wait <= 2'd0;
        end else if (~b_valid | w_b_acc) begin
            r_b_wait <= 2'd0;
        end else if (r_b_wait != 2'd3) begin
            r_b_wait <= r_b_wait + 2'd1;
        end else begin
            r_b_wait <= r_b_wait;
        end
    end

    assign w_q_addr[0] = q_addr1;
    assign w_q_addr[1] = q_addr2;

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_idx = {PW{1'b0}};
        for (int q = 0; q < 2; q++) begin
            w_q_hit[q]  = 1'b0;
            w_q_data[q] = 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = r_rd_ptr + PW'(i);
                if ((CW'(i) < r_count) && (w_q_addr[q] != 5'd0) &&
                    (r_addr[w_idx] == w_q_addr[q])) begin
                    w_q_hit[q]  = 1'b1;
                    w_q_data[q] = r_data[w_idx];
                end else begin
                    w_q_hit[q]  = w_q_hit[q];
                    w_q_data[q] = w_q_data[q];
                end
            end
        end
    end

    assign q_hit1  = w_q_hit[0];
    assign q_hit2  = w_q_hit[1];
    assign q_data1 = w_q_data[0];
    assign q_data2 = w_q_data[1];

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: a queue-based model of pending writes is compared against the
// DUT every cycle, with directed scenarios carrying hand-computed literal expectations.
module tb_rf_write_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, wb_hold;
    logic [4:0]  a_addr, b_addr, q_addr1, q_addr2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, rf_wen, q_hit1, q_hit2;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w, q_data1, q_data2;

    rf_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wb_hold(wb_hold),
        .rf_wen(rf_wen), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .q_addr1(q_addr1), .q_addr2(q_addr2),
        .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t pend[$];
    int   bwait;
    int   n_cmp;
    int   n_bad;

    logic        e_a_ready, e_b_ready, e_wen, e_a_acc, e_b_acc;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [32:0] e_q1, e_q2;

    function automatic logic [32:0] mdl_lookup(input logic [4:0] q);
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (q != 5'd0 && pend[i].addr == q) return {1'b1, pend[i].data};
        end
        return 33'd0;
    endfunction

    task automatic compute();
        logic starve;
        logic space;
        starve    = (bwait == 3);
        space     = (pend.size() < DEPTH);
        e_a_ready = !rst && space && !(b_valid && starve);
        e_b_ready = !rst && space && (!a_valid || starve);
        e_a_acc   = a_valid && e_a_ready;
        e_b_acc   = b_valid && e_b_ready;
        e_wen     = !rst && (pend.size() != 0) && !wb_hold;
        e_addr    = (pend.size() != 0) ? pend[0].addr : 5'd0;
        e_data    = (pend.size() != 0) ? pend[0].data : 32'd0;
        e_q1      = mdl_lookup(q_addr1);
        e_q2      = mdl_lookup(q_addr2);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Mid-cycle comparison of every DUT output against the model.
    task automatic eval();
        #3;
        compute();
        chk("a_ready",   32'(a_ready),   32'(e_a_ready));
        chk("b_ready",   32'(b_ready),   32'(e_b_ready));
        chk("rf_wen",    32'(rf_wen),    32'(e_wen));
        chk("rf_addr_w", 32'(rf_addr_w), 32'(e_addr));
        chk("rf_data_w", rf_data_w,      e_data);
        chk("q_hit1",    32'(q_hit1),    32'(e_q1[32]));
        chk("q_data1",   q_data1,        e_q1[31:0]);
        chk("q_hit2",    32'(q_hit2),    32'(e_q2[32]));
        chk("q_data2",   q_data2,        e_q2[31:0]);
    endtask

    // Advance one clock and apply the handshake/pop rules to the model.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        compute();
        if (rst) begin
            pend.delete();
            bwait = 0;
        end else begin
            if (e_wen) void'(pend.pop_front());
            if (e_b_acc && b_addr != 5'd0) begin
                e.addr = b_addr; e.data = b_data; pend.push_back(e);
            end else if (e_a_acc && a_addr != 5'd0) begin
                e.addr = a_addr; e.data = a_data; pend.push_back(e);
            end
            if (!b_valid || e_b_acc) bwait = 0;
            else if (bwait < 3) bwait++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        q_addr1 = 5'd0; q_addr2 = 5'd0;
    endtask

    initial begin
        logic a_acc_last, b_acc_last;
        n_cmp = 0; n_bad = 0; bwait = 0;
        rst = 1'b1; wb_hold = 1'b0;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;

        // Reset state
        eval();
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_rf_wen",  32'(rf_wen),  32'd0);
        tick();

        // Single write appears the following cycle
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
        eval();
        chk("w1_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        eval();
        chk("w1_wen", 32'(rf_wen), 32'd1);
        chk("w1_addr", 32'(rf_addr_w), 32'd5);
        chk("w1_data", rf_data_w, 32'h11);
        tick();
        eval();
        chk("w1_wen_after", 32'(rf_wen), 32'd0);
        tick();

        // Fill under hold, lookup, then drain in order
        wb_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            a_valid = 1'b1; a_addr = 5'(k); a_data = 32'(k);
            eval(); tick();
        end
        a_addr = 5'd9; a_data = 32'h99; q_addr1 = 5'd3;
        eval();
        chk("full_a_ready", 32'(a_ready), 32'd0);
        chk("full_q_hit1",  32'(q_hit1),  32'd1);
        chk("full_q_data1", q_data1,      32'd3);
        tick();
        a_valid = 1'b0; wb_hold = 1'b0; q_addr1 = 5'd0;
        for (int k = 1; k <= 4; k++) begin
            eval();
            chk("drain_wen",  32'(rf_wen),    32'd1);
            chk("drain_addr", 32'(rf_addr_w), 32'(k));
            tick();
        end
        eval();
        chk("drain_done", 32'(rf_wen), 32'd0);
        tick();

        // Same register twice: youngest forwarded, oldest written first
        wb_hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hA; eval(); tick();
        a_data = 32'hB; eval(); tick();
        a_valid = 1'b0; q_addr2 = 5'd7;
        eval();
        chk("dup_hit2",  32'(q_hit2), 32'd1);
        chk("dup_data2", q_data2,     32'hB);
        tick();
        wb_hold = 1'b0;
        eval();
        chk("dup_first", rf_data_w, 32'hA);
        tick();
        eval();
        chk("dup_second", rf_data_w, 32'hB);
        tick();
        q_addr2 = 5'd0;

        // Write to r0 is acknowledged but dropped
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
        eval();
        chk("r0_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        eval();
        chk("r0_wen", 32'(rf_wen), 32'd0);
        tick();

        // Starvation: B wins on its fourth waiting cycle
        wb_hold = 1'b1;
        b_valid = 1'b1; b_addr = 5'd20; b_data = 32'hB0B0;
        for (int k = 1; k <= 4; k++) begin
            a_valid = 1'b1; a_addr = 5'(10 + k); a_data = 32'(k);
            eval();
            chk("stv_a_ready", 32'(a_ready), (k == 4) ? 32'd0 : 32'd1);
            chk("stv_b_ready", 32'(b_ready), (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs(); wb_hold = 1'b0;
        for (int k = 0; k < 5; k++) begin eval(); tick(); end

        // Reset with three entries pending
        wb_hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            a_valid = 1'b1; a_addr = 5'(k + 3); a_data = 32'(k + 100);
            eval(); tick();
        end
        a_valid = 1'b0; rst = 1'b1;
        eval();
        chk("rstmid_wen", 32'(rf_wen), 32'd0);
        tick();
        rst = 1'b0; wb_hold = 1'b0; q_addr1 = 5'd4; q_addr2 = 5'd6;
        for (int k = 0; k < 3; k++) begin
            eval();
            chk("rstmid_wen_after", 32'(rf_wen), 32'd0);
            chk("rstmid_hit1", 32'(q_hit1), 32'd0);
            tick();
        end

        // Randomized traffic; requesters hold their request until accepted
        idle_inputs();
        a_acc_last = 1'b0; b_acc_last = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!a_valid || a_acc_last) begin
                a_valid = ($urandom_range(3, 0) != 0);
                a_addr  = 5'($urandom_range(7, 0));
                a_data  = $urandom;
            end
            if (!b_valid || b_acc_last) begin
                b_valid = ($urandom_range(2, 0) == 0);
                b_addr  = 5'($urandom_range(7, 0));
                b_data  = $urandom;
            end
            wb_hold = ($urandom_range(9, 0) < 4);
            rst     = ($urandom_range(99, 0) == 0);
            q_addr1 = 5'($urandom_range(7, 0));
            q_addr2 = 5'($urandom_range(7, 0));
            eval();
            a_acc_last = e_a_acc;
            b_acc_last = e_b_acc;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
